// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory-port arbiter.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    localparam logic [31:0] WDOG_DATA = 32'hDEADBEEF;

    // Width of the starvation counter; covers STARVE_LIMIT up to 15.
    localparam int unsigned STARVE_CW = 4;

endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// Winner selection between fetch and data requesters, with the fetch anti-starvation counter.
import mem_bus_arbiter_pkg::*;

module mem_bus_arbiter_pick #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic    i_clk,
    input  logic    i_reset,
    input  logic    i_idle,
    input  logic    i_ireq,
    input  logic    i_dreq,
    output req_id_t o_winner,
    output logic    o_grant_vld
);

    logic [STARVE_CW-1:0] r_starve_cnt;
    logic                 w_starved;

    assign w_starved   = i_ireq && (r_starve_cnt == STARVE_CW'(STARVE_LIMIT));
    assign o_winner    = (i_dreq && !w_starved) ? REQ_D : REQ_I;
    assign o_grant_vld = i_idle && (i_ireq || i_dreq);

    // Counts data grants that overtook a pending fetch; only IDLE cycles can change it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_starve_cnt <= '0;
        end else if (i_idle) begin
            if (!i_ireq) begin
                r_starve_cnt <= '0;
            end else if (o_grant_vld && (o_winner == REQ_I)) begin
                r_starve_cnt <= '0;
            end else if (o_grant_vld && !w_starved) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding memory-port arbiter for MIPS fetch/data requesters.
// Optional watchdog abort enabled by defining MEM_BUS_ARBITER_WATCHDOG_EN.
import mem_bus_arbiter_pkg::*;

module mem_bus_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ireq,
    input  logic [AW-1:0] iadr,
    output logic          idone,
    input  logic          dreq,
    input  logic          dwe,
    input  logic [AW-1:0] dadr,
    input  logic [DW-1:0] dwdata,
    output logic          ddone,
    output logic [DW-1:0] rdata,
    output logic          mreq,
    output logic          mwe,
    output logic [AW-1:0] madr,
    output logic [DW-1:0] mwdata,
    input  logic          mack,
    input  logic [DW-1:0] mrdata,
    output logic          busy,
    output logic          err
);

    state_t        r_state;
    state_t        w_state_nxt;
    req_id_t       r_winner;
    logic [AW-1:0] r_adr;
    logic          r_we;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    req_id_t       w_winner;
    logic          w_grant_vld;
    logic          w_timeout;

    mem_bus_arbiter_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_idle      (r_state == IDLE),
        .i_ireq      (ireq),
        .i_dreq      (dreq),
        .o_winner    (w_winner),
        .o_grant_vld (w_grant_vld)
    );

`ifdef MEM_BUS_ARBITER_WATCHDOG_EN
    logic [15:0] r_wdog_cnt;
    logic        r_err;

    // Held at zero outside BUSY, so every BUSY entry starts a fresh count.
    always_ff @(posedge clk) begin
        if (reset || (r_state != BUSY)) begin
            r_wdog_cnt <= '0;
        end else begin
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == BUSY) && !mack && (r_wdog_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT == 0);
    assign w_timeout        = 1'b0;
    assign err              = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant_vld) w_state_nxt = BUSY;
            BUSY:    if (mack || w_timeout) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request fields are captured once at grant and held for the whole transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_winner <= REQ_I;
            r_adr    <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else begin
            if ((r_state == IDLE) && w_grant_vld) begin
                r_winner <= w_winner;
                if (w_winner == REQ_D) begin
                    r_adr   <= dadr;
                    r_we    <= dwe;
                    r_wdata <= dwdata;
                end else begin
                    r_adr   <= iadr;
                    r_we    <= 1'b0;
                    r_wdata <= '0;
                end
            end
            if ((r_state == BUSY) && mack && !r_we) begin
                r_rdata <= mrdata;
            end else if (w_timeout) begin
                r_rdata <= DW'(WDOG_DATA);
            end
        end
    end

    assign mreq   = (r_state == BUSY);
    assign mwe    = (r_state == BUSY) && r_we;
    assign madr   = r_adr;
    assign mwdata = r_wdata;
    assign busy   = (r_state != IDLE);
    assign idone  = (r_state == DONE) && (r_winner == REQ_I);
    assign ddone  = (r_state == DONE) && (r_winner == REQ_D);
    assign rdata  = r_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reset, read, write, contention, starvation, watchdog.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq;
    logic [31:0] iadr;
    logic        idone;
    logic        dreq;
    logic        dwe;
    logic [31:0] dadr;
    logic [31:0] dwdata;
    logic        ddone;
    logic [31:0] rdata;
    logic        mreq;
    logic        mwe;
    logic [31:0] madr;
    logic [31:0] mwdata;
    logic        mack;
    logic [31:0] mrdata;
    logic        busy;
    logic        err;

    int n_chk  = 0;
    int n_pass = 0;
    int n_busy;

    mem_bus_arbiter #(
        .AW (32), .DW (32), .STARVE_LIMIT (4), .TIMEOUT (64)
    ) dut (
        .clk    (clk),    .reset  (reset),
        .ireq   (ireq),   .iadr   (iadr),   .idone (idone),
        .dreq   (dreq),   .dwe    (dwe),    .dadr  (dadr),
        .dwdata (dwdata), .ddone  (ddone),  .rdata (rdata),
        .mreq   (mreq),   .mwe    (mwe),    .madr  (madr),
        .mwdata (mwdata), .mack   (mack),   .mrdata (mrdata),
        .busy   (busy),   .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; ireq = 1'b0; iadr = '0; dreq = 1'b0; dwe = 1'b0;
        dadr = '0; dwdata = '0; mack = 1'b0; mrdata = '0;
        tick(); tick();
        chk("rst_mreq", 32'(mreq), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", {30'd0, idone, ddone}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_madr", madr, 0);
        chk("rst_err", 32'(err), 0);
        reset = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 0);

        // Single fetch read with zero-wait memory.
        ireq = 1'b1; iadr = 32'h0000_0040;
        tick();
        chk("rd_mreq", 32'(mreq), 1);
        chk("rd_madr", madr, 32'h40);
        chk("rd_mwe", 32'(mwe), 0);
        mack = 1'b1; mrdata = 32'h2002_0005;
        tick();
        chk("rd_idone", 32'(idone), 1);
        chk("rd_ddone", 32'(ddone), 0);
        chk("rd_mreq_done", 32'(mreq), 0);
        chk("rd_rdata", rdata, 32'h2002_0005);
        ireq = 1'b0; mack = 1'b0; mrdata = 32'h0BAD_0BAD;
        tick();
        chk("rd_idone_pulse", 32'(idone), 0);
        chk("rd_idle", 32'(busy), 0);

        // Data write with three wait cycles.
        dreq = 1'b1; dwe = 1'b1; dadr = 32'h14; dwdata = 32'd21;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("wr_mreq", 32'(mreq), 1);
            chk("wr_mwe", 32'(mwe), 1);
            chk("wr_madr", madr, 32'h14);
            chk("wr_mwdata", mwdata, 32'd21);
            if (k == 3) mack = 1'b1;
            tick();
        end
        chk("wr_ddone", 32'(ddone), 1);
        chk("wr_idone", 32'(idone), 0);
        chk("wr_rdata_kept", rdata, 32'h2002_0005);
        dreq = 1'b0; dwe = 1'b0; mack = 1'b0;
        tick();
        chk("wr_ddone_pulse", 32'(ddone), 0);

        // Contention: data first, then fetch, with an idle gap between.
        dreq = 1'b1; dadr = 32'h100; ireq = 1'b1; iadr = 32'h200;
        tick();
        chk("ct_first_madr", madr, 32'h100);
        mack = 1'b1; mrdata = 32'h1111_1111;
        tick();
        chk("ct_first_done", {30'd0, idone, ddone}, 32'b01);
        chk("ct_first_rdata", rdata, 32'h1111_1111);
        dreq = 1'b0; mack = 1'b0;
        tick();
        chk("ct_gap_mreq", 32'(mreq), 0);
        chk("ct_cnt_after_d", 32'(dut.u_pick.r_starve_cnt), 1);
        tick();
        chk("ct_second_mreq", 32'(mreq), 1);
        chk("ct_second_madr", madr, 32'h200);
        mack = 1'b1; mrdata = 32'h2222_2222;
        tick();
        chk("ct_second_done", {30'd0, idone, ddone}, 32'b10);
        chk("ct_second_rdata", rdata, 32'h2222_2222);
        ireq = 1'b0; mack = 1'b0;
        tick();

        // Starvation: fetch held, data re-raised every IDLE.
        ireq = 1'b1; iadr = 32'h300;
        for (int g = 0; g < 5; g++) begin
            dreq = 1'b1; dadr = 32'h400 + 32'(g);
            tick();
            chk("sv_madr", madr, (g < 4) ? 32'h400 + 32'(g) : 32'h300);
            if (g == 3) chk("sv_cnt_sat", 32'(dut.u_pick.r_starve_cnt), 4);
            if (g == 4) chk("sv_cnt_clr", 32'(dut.u_pick.r_starve_cnt), 0);
            mack = 1'b1; mrdata = 32'h5000 + 32'(g);
            tick();
            chk("sv_done", {30'd0, idone, ddone}, (g < 4) ? 32'b01 : 32'b10);
            dreq = 1'b0; mack = 1'b0;
            if (g == 4) ireq = 1'b0;
            tick();
        end

        // Data read with no acknowledge: watchdog abort or indefinite wait.
        dreq = 1'b1; dwe = 1'b0; dadr = 32'h500;
        tick();
        n_busy = 0;
        while (mreq && n_busy < 70) begin
            n_busy++;
            tick();
        end
`ifdef MEM_BUS_ARBITER_WATCHDOG_EN
        chk("wd_busy_cycles", 32'(n_busy), 64);
        chk("wd_ddone", 32'(ddone), 1);
        chk("wd_rdata", rdata, 32'hDEADBEEF);
        chk("wd_err", 32'(err), 1);
        dreq = 1'b0;
        tick();
        chk("wd_err_sticky", 32'(err), 1);
        dreq = 1'b1; dadr = 32'h600;
        tick();
        tick();
`else
        chk("nowd_busy_cycles", 32'(n_busy), 70);
        chk("nowd_err", 32'(err), 0);
`endif

        // Reset asserted for two cycles while BUSY.
        chk("pre_rst_mreq", 32'(mreq), 1);
        reset = 1'b1;
        tick();
        chk("mid_rst_mreq", 32'(mreq), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", {30'd0, idone, ddone}, 0);
        chk("mid_rst_err", 32'(err), 0);
        dreq = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_mreq", 32'(mreq), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
